// File: rtl/vid_pkg.sv
// Shared raster timing constants and types for the SE-VGA timing generator.
// Defaults describe 640x480@60 with a centred 512x342 Mac SE window.
package vid_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int WIN_W    = 512;
  localparam int WIN_H    = 342;

  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_START    = (H_ACTIVE - WIN_W) / 2;
  localparam int H_END      = H_START + WIN_W;
  localparam int V_START    = (V_ACTIVE - WIN_H) / 2;
  localparam int V_END      = V_START + WIN_H;
  localparam int VRAM_BYTES = (WIN_W / 8) * WIN_H;

  typedef logic [14:0] vram_addr_t;

endpackage

// File: rtl/vid_timing_gen_if.sv
// Raster timing bundle: sync, shifter sequencing and VRAM fetch signals.
// The generator drives it through master; the shift-out stage and arbiter listen on slave.
interface vid_timing_gen_if;
  import vid_pkg::*;

  logic       hSync;
  logic       vSync;
  logic       vidActive;
  logic [2:0] seq;
  vram_addr_t vramAddr;
  logic       vramRd;
  logic       frameStart;

  modport master (
    output hSync, vSync, vidActive, seq, vramAddr, vramRd, frameStart
  );

  modport slave (
    input  hSync, vSync, vidActive, seq, vramAddr, vramRd, frameStart
  );

endinterface

// File: rtl/vid_mod_counter.sv
// Modulo-N up counter with enable and wrap pulse. Exposes the next-state value
// so the owner can register outputs that line up with the counter itself.
module vid_mod_counter #(
  parameter int N = 800,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         en,
  output logic [W-1:0] nxt,
  output logic         wrap
);

  logic [W-1:0] cnt;

  always_comb begin
    wrap = en && (cnt == W'(N - 1));
    nxt  = cnt;
    if (en) begin
      nxt = wrap ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      cnt <= '0;
    end else begin
      cnt <= nxt;
    end
  end

endmodule

// File: rtl/vid_timing_gen.sv
// VGA raster timing generator with a centred fetch window for the Mac SE shifter.
// Every output is decoded from next-state counters so it matches the counter value of its cycle.
module vid_timing_gen
  import vid_pkg::*;
#(
  parameter int H_ACTIVE = vid_pkg::H_ACTIVE,
  parameter int H_FP     = vid_pkg::H_FP,
  parameter int H_SYNC   = vid_pkg::H_SYNC,
  parameter int H_BP     = vid_pkg::H_BP,
  parameter int V_ACTIVE = vid_pkg::V_ACTIVE,
  parameter int V_FP     = vid_pkg::V_FP,
  parameter int V_SYNC   = vid_pkg::V_SYNC,
  parameter int V_BP     = vid_pkg::V_BP,
  parameter int WIN_W    = vid_pkg::WIN_W,
  parameter int WIN_H    = vid_pkg::WIN_H
) (
  input  logic              clk,
  input  logic              nReset,
  vid_timing_gen_if.master  vid
);

  localparam int HTOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VTOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW   = $clog2(HTOT);
  localparam int VW   = $clog2(VTOT);
  // Fetch window leads the visible window by one byte so byte 0 is loaded in time.
  localparam int FS   = (H_ACTIVE - WIN_W) / 2 - 8;
  localparam int FE   = FS + WIN_W;
  localparam int VS   = (V_ACTIVE - WIN_H) / 2;
  localparam int VE   = VS + WIN_H;
  localparam int HSS  = H_ACTIVE + H_FP;
  localparam int HSE  = HSS + H_SYNC;
  localparam int VSS  = V_ACTIVE + V_FP;
  localparam int VSE  = VSS + V_SYNC;

  logic [HW-1:0] hNext;
  logic [VW-1:0] vNext;
  logic          hWrap;
  logic          vWrap;

  vid_mod_counter #(.N(HTOT), .W(HW)) u_hcnt (
    .clk    (clk),
    .nReset (nReset),
    .en     (1'b1),
    .nxt    (hNext),
    .wrap   (hWrap)
  );

  vid_mod_counter #(.N(VTOT), .W(VW)) u_vcnt (
    .clk    (clk),
    .nReset (nReset),
    .en     (hWrap),
    .nxt    (vNext),
    .wrap   (vWrap)
  );

  logic       act_p0;
  logic [2:0] seq_p0;
  logic       rd_p0;
  logic       hs_p0;
  logic       vs_p0;

  // stage 0: decode from next-state counter values
  always_comb begin
    act_p0 = (hNext >= HW'(FS)) && (hNext < HW'(FE)) &&
             (vNext >= VW'(VS)) && (vNext < VW'(VE));
    seq_p0 = act_p0 ? 3'(hNext - HW'(FS)) : 3'd0;
    rd_p0  = act_p0 && (seq_p0 == 3'd4);
    hs_p0  = !((hNext >= HW'(HSS)) && (hNext < HW'(HSE)));
    vs_p0  = !((vNext >= VW'(VSS)) && (vNext < VW'(VSE)));
  end

  // stage 1: registered outputs and VRAM address counter
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      vid.hSync      <= 1'b1;
      vid.vSync      <= 1'b1;
      vid.vidActive  <= 1'b0;
      vid.seq        <= 3'd0;
      vid.vramRd     <= 1'b0;
      vid.frameStart <= 1'b0;
      vid.vramAddr   <= '0;
    end else begin
      vid.hSync      <= hs_p0;
      vid.vSync      <= vs_p0;
      vid.vidActive  <= act_p0;
      vid.seq        <= seq_p0;
      vid.vramRd     <= rd_p0;
      vid.frameStart <= vWrap;
      // Mac rows are contiguous, so the address only ever clears at frame wrap.
      if (vWrap) begin
        vid.vramAddr <= '0;
      end else if (vid.vidActive && (vid.seq == 3'd7)) begin
        vid.vramAddr <= vid.vramAddr + vram_addr_t'(1);
      end
    end
  end

endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen on a scaled raster (100x48 frame, 32x20 window) so whole
// frames, mid-frame reset and frame-to-frame spacing fit in a short run.
module tb_vid_timing_gen;
  import vid_pkg::*;

  localparam int HA = 80, HFP = 4, HSY = 8, HBP = 8;
  localparam int VA = 40, VFP = 2, VSY = 2, VBP = 4;
  localparam int WW = 32, WH = 20;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FRAME  = HT * VT;
  localparam int FS     = (HA - WW) / 2 - 8;
  localparam int FE     = FS + WW;
  localparam int VS0    = (VA - WH) / 2;
  localparam int VE0    = VS0 + WH;
  localparam int BPL    = WW / 8;
  localparam int NBYTES = BPL * WH;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
    logic [2:0] seq;
    vram_addr_t addr;
    logic       rd;
    logic       fs;
  } exp_t;

  localparam exp_t RST_VAL = '{hs: 1'b1, vs: 1'b1, act: 1'b0, seq: 3'd0,
                               addr: '0, rd: 1'b0, fs: 1'b0};

  logic clk = 1'b0;
  logic nReset = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   mh = 0;
  int   mv = 0;
  exp_t sb[$];

  vid_timing_gen_if vif ();

  vid_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP),
    .WIN_W    (WW), .WIN_H (WH)
  ) dut (
    .clk    (clk),
    .nReset (nReset),
    .vid    (vif)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input int h, input int v);
    exp_t e;
    int   a;
    int   c;
    e.hs  = !(h >= HA + HFP && h < HA + HFP + HSY);
    e.vs  = !(v >= VA + VFP && v < VA + VFP + VSY);
    e.act = (h >= FS) && (h < FE) && (v >= VS0) && (v < VE0);
    e.seq = e.act ? 3'((h - FS) % 8) : 3'd0;
    e.rd  = e.act && (e.seq == 3'd4);
    e.fs  = (h == 0) && (v == 0);
    if (v < VS0) begin
      a = 0;
    end else if (v >= VE0) begin
      a = NBYTES;
    end else begin
      c = (h <= FS + 7) ? 0 : (h - FS - 8) / 8 + 1;
      if (c > BPL) c = BPL;
      a = BPL * (v - VS0) + c;
    end
    e.addr = 15'(a);
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t g;
    g.hs   = vif.hSync;
    g.vs   = vif.vSync;
    g.act  = vif.vidActive;
    g.seq  = vif.seq;
    g.addr = vif.vramAddr;
    g.rd   = vif.vramRd;
    g.fs   = vif.frameStart;
    return g;
  endfunction

  task automatic step();
    @(posedge clk);
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv++;
      if (mv == VT) mv = 0;
    end
    sb.push_back(model(mh, mv));
    @(negedge clk);
  endtask

  task automatic abort_if_flooded();
    if (bad > 40) begin
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    nReset = 1'b1;
    mh = 0;
    mv = 0;
    sb.delete();
  endtask

  task automatic test_reset();
    exp_t g;
    nReset = 1'b0;
    repeat (3) @(negedge clk);
    g = sample();
    total++; if (g.hs !== 1'b1) begin bad++; $display("FAIL reset_hSync got=%b exp=1", g.hs); end
    total++; if (g.vs !== 1'b1) begin bad++; $display("FAIL reset_vSync got=%b exp=1", g.vs); end
    total++; if (g.act !== 1'b0) begin bad++; $display("FAIL reset_vidActive got=%b exp=0", g.act); end
    total++; if (g.seq !== 3'd0) begin bad++; $display("FAIL reset_seq got=%0d exp=0", g.seq); end
    total++; if (g.addr !== 15'd0) begin bad++; $display("FAIL reset_vramAddr got=%0d exp=0", g.addr); end
    total++; if (g.rd !== 1'b0) begin bad++; $display("FAIL reset_vramRd got=%b exp=0", g.rd); end
    total++; if (g.fs !== 1'b0) begin bad++; $display("FAIL reset_frameStart got=%b exp=0", g.fs); end
    release_reset();
  endtask

  task automatic test_frame();
    exp_t e, g;
    int hs_low = 0, vs_low = 0, fs_n = 0, rd_n = 0;
    int first_hs = -1, first_vs = -1, a_line = -1, a_end = -1;
    for (int i = 0; i < FRAME; i++) begin
      step();
      e = sb.pop_front();
      g = sample();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL frame_cycle h=%0d v=%0d got=%h exp=%h", mh, mv, g, e);
      end
      if (!g.hs) hs_low++;
      if (!g.hs && mv == 0 && first_hs < 0) first_hs = mh;
      if (!g.vs) vs_low++;
      if (!g.vs && first_vs < 0) first_vs = mv;
      if (g.fs) fs_n++;
      if (g.rd) rd_n++;
      if (mh == 0 && mv == VS0 + 1) a_line = int'(g.addr);
      if (mh == 0 && mv == VE0) a_end = int'(g.addr);
      abort_if_flooded();
    end
    total++; if (hs_low != HSY * VT) begin bad++; $display("FAIL hsync_low_cycles got=%0d exp=%0d", hs_low, HSY * VT); end
    total++; if (first_hs != HA + HFP) begin bad++; $display("FAIL hsync_start got=%0d exp=%0d", first_hs, HA + HFP); end
    total++; if (vs_low != VSY * HT) begin bad++; $display("FAIL vsync_low_cycles got=%0d exp=%0d", vs_low, VSY * HT); end
    total++; if (first_vs != VA + VFP) begin bad++; $display("FAIL vsync_start_line got=%0d exp=%0d", first_vs, VA + VFP); end
    total++; if (fs_n != 1) begin bad++; $display("FAIL framestart_count got=%0d exp=1", fs_n); end
    total++; if (rd_n != NBYTES) begin bad++; $display("FAIL vramrd_count got=%0d exp=%0d", rd_n, NBYTES); end
    total++; if (a_line != BPL) begin bad++; $display("FAIL addr_after_first_line got=%0d exp=%0d", a_line, BPL); end
    total++; if (a_end != NBYTES) begin bad++; $display("FAIL addr_after_last_line got=%0d exp=%0d", a_end, NBYTES); end
    total++; if (g.fs !== 1'b1 || g.addr !== 15'd0) begin bad++; $display("FAIL frame_wrap got fs=%b addr=%0d exp fs=1 addr=0", g.fs, g.addr); end
  endtask

  task automatic test_window();
    exp_t e, g;
    int rise = -1, fall = -1, first_rd = -1, last_rd = -1, rd_line = 0, outside = 0, a_hold = -1;
    for (int i = 0; i < (VE0 + 1) * HT; i++) begin
      step();
      e = sb.pop_front();
      g = sample();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL window_cycle h=%0d v=%0d got=%h exp=%h", mh, mv, g, e);
      end
      if (mv == VS0) begin
        if (g.act && rise < 0) rise = mh;
        if (!g.act && rise >= 0 && fall < 0) fall = mh;
        if (g.rd) begin
          rd_line++;
          if (first_rd < 0) first_rd = mh;
          last_rd = mh;
        end
      end
      if ((mv == VS0 - 1 || mv == VE0) && (g.act || g.rd)) outside++;
      if (mv == VE0 && mh == HT - 1) a_hold = int'(g.addr);
      abort_if_flooded();
    end
    total++; if (rise != FS) begin bad++; $display("FAIL window_rise got=%0d exp=%0d", rise, FS); end
    total++; if (fall != FE) begin bad++; $display("FAIL window_fall got=%0d exp=%0d", fall, FE); end
    total++; if (rd_line != BPL) begin bad++; $display("FAIL line_rd_count got=%0d exp=%0d", rd_line, BPL); end
    total++; if (first_rd != FS + 4) begin bad++; $display("FAIL first_rd_pos got=%0d exp=%0d", first_rd, FS + 4); end
    total++; if (last_rd != FE - 4) begin bad++; $display("FAIL last_rd_pos got=%0d exp=%0d", last_rd, FE - 4); end
    total++; if (outside != 0) begin bad++; $display("FAIL boundary_lines_active got=%0d exp=0", outside); end
    total++; if (a_hold != NBYTES) begin bad++; $display("FAIL addr_hold_after_window got=%0d exp=%0d", a_hold, NBYTES); end
  endtask

  task automatic test_midframe_reset();
    exp_t e, g;
    int n = 0;
    int guard = 0;
    while (!(mv == 25 && mh == 30) && guard < 2 * FRAME) begin
      step();
      e = sb.pop_front();
      g = sample();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL prereset_cycle h=%0d v=%0d got=%h exp=%h", mh, mv, g, e);
      end
      guard++;
      abort_if_flooded();
    end
    total++; if (guard >= 2 * FRAME) begin bad++; $display("FAIL reach_reset_point got=%0d cycles exp<%0d", guard, 2 * FRAME); end
    #2 nReset = 1'b0;
    #1 g = sample();
    total++; if (g !== RST_VAL) begin bad++; $display("FAIL async_reset got=%h exp=%h", g, RST_VAL); end
    repeat (3) @(negedge clk);
    g = sample();
    total++; if (g !== RST_VAL) begin bad++; $display("FAIL held_reset got=%h exp=%h", g, RST_VAL); end
    release_reset();
    do begin
      step();
      n++;
      e = sb.pop_front();
      g = sample();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL postreset_cycle h=%0d v=%0d got=%h exp=%h", mh, mv, g, e);
      end
      abort_if_flooded();
    end while (!g.fs && n < 2 * FRAME);
    total++; if (n != FRAME) begin bad++; $display("FAIL reset_to_framestart got=%0d exp=%0d", n, FRAME); end
  endtask

  task automatic test_back_to_back();
    exp_t e, g;
    int n = 0;
    int rd_n = 0;
    do begin
      step();
      n++;
      e = sb.pop_front();
      g = sample();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL b2b_cycle h=%0d v=%0d got=%h exp=%h", mh, mv, g, e);
      end
      if (g.rd) rd_n++;
      abort_if_flooded();
    end while (!g.fs && n < 2 * FRAME);
    total++; if (n != FRAME) begin bad++; $display("FAIL framestart_period got=%0d exp=%0d", n, FRAME); end
    total++; if (rd_n != NBYTES) begin bad++; $display("FAIL b2b_rd_count got=%0d exp=%0d", rd_n, NBYTES); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_window();
    test_midframe_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vid_timing_gen.md
# vid_timing_gen

Raster timing generator for the SE-VGA output path. It produces 640x480@60 VGA sync from the 25.175 MHz pixel clock and centres the 512x342 Mac SE window inside the frame. It drives the byte-sequence, window-enable and VRAM byte-address signals consumed by the video shift-out stage, plus a frame-start pulse for the bus side.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths (line total 800)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths (frame total 525)
- WIN_W, 512, Mac window width in pixels; must be a multiple of 8
- WIN_H, 342, Mac window height in lines

Ports:
- clk  in  1  pixel clock, 25.175 MHz; all state updates on posedge
- nReset  in  1  reset, asynchronous, active-low
- hSync  out  1  VGA horizontal sync, active-low
- vSync  out  1  VGA vertical sync, active-low
- vidActive  out  1  high while the shifter must load and shift (fetch window)
- seq  out  3  pixel index within the current byte, 0..7
- vramAddr  out  15  byte address of the next VRAM fetch, 0..21887
- vramRd  out  1  one-cycle read strobe to VRAM arbiter
- frameStart  out  1  one-cycle pulse at start of frame

## Operation
- hCount 0..799 and vCount 0..524; hCount 0 / vCount 0 = first visible pixel / line. hCount wraps 799->0; vCount advances only on hCount wrap and wraps 524->0.
- H window: H_START = (H_ACTIVE-WIN_W)/2 = 64, H_END = 576. Fetch window = [H_START-8, H_END-8) = [56, 568): 512 cycles = 64 bytes, one byte of prefetch lead.
- V window: V_START = (V_ACTIVE-WIN_H)/2 = 69, V_END = 411.
- vidActive = 1 iff hCount in [56,568) and vCount in [69,411).
- seq = (hCount - 56) mod 8 = hCount[2:0]. seq is 0 outside the window.
- vramRd = 1 when vidActive and seq == 4. This gives the arbiter 3 cycles before the shifter latches the data at seq 7.
- vramAddr is held at 0 from frame start until the window opens. It increments by 1 on the posedge where vidActive and seq == 7.
  - After the last fetch of line 410 it reads 21888.
  - It clears to 0 when vCount wraps. There is no per-line reload; Mac rows are 64 contiguous bytes.
- hSync = 0 iff hCount in [656,752).
- vSync = 0 iff vCount in [490,492).
- frameStart = 1 for exactly the cycle in which hCount == 0 and vCount == 0.
- All outputs are registered. Each is decoded from the next-state counter values, so it aligns with the counter value present in the same cycle and is glitch-free.

## Timing
- Reset values: hCount = 0, vCount = 0, hSync = 1, vSync = 1, vidActive = 0, seq = 0, vramAddr = 0, vramRd = 0, frameStart = 0.
- frameStart does not fire on the first cycle after reset. Its first pulse comes after a full 800x525 frame.
- Reset asserted mid-frame: all state returns to reset values immediately. After release, counting restarts at hCount 0 on the first posedge.
- Shifter interface: the shifter samples seq and vidActive on negedge, half a cycle after they update.
  - seq 7 at hCount 63 latches byte 0 into the shifter's input stage.
  - seq 0 at hCount 64 moves it to the output stage.
  - The first window pixel is driven from the negedge inside hCount 64; the last from the negedge inside hCount 575.
- vramRd to data-valid budget: data must be stable on the shifter's parallel input by the negedge of seq 7.
- Line boundary: hCount 799->0 and the vCount step happen on the same posedge. vidActive computed for the new line uses the new vCount.
- Frame boundary: vCount 524->0 and the vramAddr clear happen on the same posedge. That posedge also asserts frameStart.

## Structure
- Shared package vid_pkg holds:
  - the timing constants above
  - derived H_START, H_END, V_START, V_END, H_TOTAL = 800, V_TOTAL = 525
  - VRAM_BYTES = 21888
  - typedef logic [14:0] vram_addr_t
- One sub-module, vid_mod_counter: parameterised modulo-N counter with enable, wrap pulse and async active-low reset. Instantiated twice: horizontal (always enabled) and vertical (enabled by the horizontal wrap).
- Window decode and the address counter live in vid_timing_gen.

## Test plan
- Reset release, run 800x525 cycles:
  - hSync low for exactly 96 cycles per line starting at hCount 656
  - vSync low for exactly 2 lines starting at line 490
  - frameStart pulses once per frame
- Line 69: vidActive rises at hCount 56 and falls at 568; seq cycles 0..7 sixty-four times; vramRd pulses 64 times at hCount 60, 68, ..., 564.
- Full frame: vramAddr reads 64 after line 69, 21888 after line 410, and returns to 0 at the frameStart cycle. Exactly 21888 vramRd strobes per frame.
- Lines 68 and 411 and hCount 55 / 568 on a window line: vidActive = 0, vramRd = 0, vramAddr unchanged.
- Assert nReset at line 200, hCount 300 for 3 cycles: all outputs at reset values, and the next frameStart arrives exactly 420000 cycles after release.
- Paired with the shift-out stage, VRAM model byte[a] = a[7:0]: line 69 pixels 64..71 reproduce byte 0 MSB first, pixels 72..79 reproduce byte 1.
